// File: rtl/pinmux_bbm_ctrl.sv
// Registered per-pad peripheral mux with a one-request-at-a-time config port.
// Changing a pad's select holds that pad off for GAP_CYCLES+1 edges, so two sources never contend on it.

module pinmux_bbm_pad #(
   parameter int NUM_PERIPHERALS = 4,
   parameter int SEL_WIDTH       = 3
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [SEL_WIDTH-1:0]       i_sel,
   input  logic                       i_gate,
   input  logic [NUM_PERIPHERALS-1:0] i_src_out,
   input  logic [NUM_PERIPHERALS-1:0] i_src_oe,
   output logic                       o_pad_out,
   output logic                       o_pad_oe
);
   logic d_out, d_oe;

   // Any select at or above NUM_PERIPHERALS matches no source, so the pad is parked at 0/0.
   always_comb begin
      d_out = 1'b0;
      d_oe  = 1'b0;
      for (int p = 0; p < NUM_PERIPHERALS; p++) begin
         if (int'(i_sel) == p) begin
            d_out = i_src_out[p];
            d_oe  = i_src_oe[p];
         end
      end
      if (i_gate) begin
         d_out = 1'b0;
         d_oe  = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_pad_out <= 1'b0;
         o_pad_oe  <= 1'b0;
      end else begin
         o_pad_out <= d_out;
         o_pad_oe  <= d_oe;
      end
   end
endmodule

module pinmux_bbm_ctrl #(
   parameter int                  NUM_PERIPHERALS = 4,
   parameter int                  NUM_PADS        = 8,
   parameter int                  SEL_WIDTH       = 3,
   parameter int                  PAD_IDX_WIDTH   = 3,
   parameter int                  GAP_CYCLES      = 2,
   parameter logic [SEL_WIDTH-1:0] RESET_SEL      = '1
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst,
   input  logic [NUM_PERIPHERALS*NUM_PADS-1:0]  i_peripheral_out,
   input  logic [NUM_PERIPHERALS*NUM_PADS-1:0]  i_peripheral_oe,
   input  logic                                 i_cfg_valid,
   input  logic [PAD_IDX_WIDTH-1:0]             i_cfg_pad,
   input  logic [SEL_WIDTH-1:0]                 i_cfg_sel,
   output logic                                 o_cfg_ready,
   output logic                                 o_cfg_done,
   output logic                                 o_cfg_err,
   output logic [NUM_PADS*SEL_WIDTH-1:0]        o_sel_flat,
   output logic [NUM_PADS-1:0]                  o_pad_out,
   output logic [NUM_PADS-1:0]                  o_pad_oe
);
   localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic {IDLE, GAP} state_t;

   state_t                              state;
   logic [CNT_W-1:0]                    cnt;
   logic [NUM_PADS-1:0][SEL_WIDTH-1:0]  sel_q;
   logic [NUM_PADS-1:0]                 tgt_mask;
   logic [SEL_WIDTH-1:0]                tgt_sel;

   logic [NUM_PADS-1:0]                 req_mask;
   logic [SEL_WIDTH-1:0]                cur_sel;
   logic                                pad_ok, accept, switching;
   logic [NUM_PADS-1:0]                 gate;
   logic [NUM_PADS-1:0][NUM_PERIPHERALS-1:0] src_out, src_oe;

   assign o_cfg_ready = (state == IDLE);
   assign o_sel_flat  = sel_q;
   assign accept      = i_cfg_valid && o_cfg_ready;
   assign pad_ok      = int'(i_cfg_pad) < NUM_PADS;

   // Decode the pad index with a loop so an out-of-range index simply matches nothing.
   always_comb begin
      req_mask = '0;
      cur_sel  = '0;
      for (int n = 0; n < NUM_PADS; n++) begin
         if (int'(i_cfg_pad) == n) begin
            req_mask[n] = 1'b1;
            cur_sel     = sel_q[n];
         end
      end
   end

   assign switching = accept && pad_ok && (i_cfg_sel != cur_sel);
   assign gate      = ((state == GAP) ? tgt_mask : '0) | (switching ? req_mask : '0);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= IDLE;
         cnt        <= '0;
         sel_q      <= {NUM_PADS{RESET_SEL}};
         tgt_mask   <= '0;
         tgt_sel    <= '0;
         o_cfg_done <= 1'b0;
         o_cfg_err  <= 1'b0;
      end else begin
         o_cfg_done <= 1'b0;
         o_cfg_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (!pad_ok) begin
                     o_cfg_err <= 1'b1;
                  end else if (i_cfg_sel == cur_sel) begin
                     o_cfg_done <= 1'b1;
                  end else begin
                     tgt_mask <= req_mask;
                     tgt_sel  <= i_cfg_sel;
                     cnt      <= CNT_W'(GAP_CYCLES - 1);
                     state    <= GAP;
                  end
               end
            end
            GAP: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  for (int n = 0; n < NUM_PADS; n++)
                     if (tgt_mask[n]) sel_q[n] <= tgt_sel;
                  o_cfg_done <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar n = 0; n < NUM_PADS; n++) begin : g_pad
      for (genvar p = 0; p < NUM_PERIPHERALS; p++) begin : g_src
         assign src_out[n][p] = i_peripheral_out[p*NUM_PADS+n];
         assign src_oe[n][p]  = i_peripheral_oe[p*NUM_PADS+n];
      end

      pinmux_bbm_pad #(
         .NUM_PERIPHERALS(NUM_PERIPHERALS),
         .SEL_WIDTH      (SEL_WIDTH)
      ) u_pad (
         .i_clk     (i_clk),
         .i_rst     (i_rst),
         .i_sel     (sel_q[n]),
         .i_gate    (gate[n]),
         .i_src_out (src_out[n]),
         .i_src_oe  (src_oe[n]),
         .o_pad_out (o_pad_out[n]),
         .o_pad_oe  (o_pad_oe[n])
      );
   end
endmodule

// File: tb/tb_pinmux_bbm_ctrl.sv
// Random and directed config traffic against a cycle-level model built from the switching timeline:
// a switch accepted at edge E blanks its pad for edges E..E+GAP and applies the select at E+GAP.
module tb_pinmux_bbm_ctrl;
   localparam int NP  = 4;
   localparam int NPD = 8;
   localparam int SW  = 3;
   localparam int PW  = 4;
   localparam int G   = 2;

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic [NP*NPD-1:0] i_peripheral_out, i_peripheral_oe;
   logic              i_cfg_valid;
   logic [PW-1:0]     i_cfg_pad;
   logic [SW-1:0]     i_cfg_sel;
   logic              o_cfg_ready, o_cfg_done, o_cfg_err;
   logic [NPD*SW-1:0] o_sel_flat;
   logic [NPD-1:0]    o_pad_out, o_pad_oe;

   pinmux_bbm_ctrl #(
      .NUM_PERIPHERALS(NP), .NUM_PADS(NPD), .SEL_WIDTH(SW),
      .PAD_IDX_WIDTH(PW), .GAP_CYCLES(G)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_peripheral_out(i_peripheral_out), .i_peripheral_oe(i_peripheral_oe),
      .i_cfg_valid(i_cfg_valid), .i_cfg_pad(i_cfg_pad), .i_cfg_sel(i_cfg_sel),
      .o_cfg_ready(o_cfg_ready), .o_cfg_done(o_cfg_done), .o_cfg_err(o_cfg_err),
      .o_sel_flat(o_sel_flat), .o_pad_out(o_pad_out), .o_pad_oe(o_pad_oe)
   );

   always #5 i_clk = ~i_clk;

   int n_chk = 0;
   int n_pass = 0;

   // Model: committed selects, plus the in-flight switch (pad, new select, edges of blanking left).
   int m_sel [NPD];
   int m_busy;
   int m_pad;
   int m_new;
   bit force_oe = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   task automatic model_reset();
      for (int n = 0; n < NPD; n++) m_sel[n] = 7;
      m_busy = 0;
   endtask

   function automatic logic [NPD*SW-1:0] exp_sel_flat();
      logic [NPD*SW-1:0] v;
      for (int n = 0; n < NPD; n++) v[n*SW +: SW] = SW'(m_sel[n]);
      return v;
   endfunction

   // Called just after a negedge; returns just after the following negedge.
   task automatic cycle(input bit v, input int pad, input int sel);
      logic [NP*NPD-1:0] po, pe;
      logic [NPD-1:0]    eo, eoe;
      int  g, s;
      bit  ed, ee, commit;
      po = $urandom;
      pe = force_oe ? '1 : NP*NPD'($urandom);
      i_peripheral_out = po;
      i_peripheral_oe  = pe;
      i_cfg_valid = v;
      i_cfg_pad   = PW'(pad);
      i_cfg_sel   = SW'(sel);
      #1;
      chk("ready", o_cfg_ready, m_busy == 0);
      g = -1; ed = 0; ee = 0; commit = 0;
      if (m_busy > 0) begin
         g = m_pad;
         m_busy--;
         if (m_busy == 0) begin commit = 1; ed = 1; end
      end else if (v) begin
         if (pad >= NPD) ee = 1;
         else if (sel == m_sel[pad]) ed = 1;
         else begin g = pad; m_pad = pad; m_new = sel; m_busy = G; end
      end
      for (int n = 0; n < NPD; n++) begin
         s = m_sel[n];
         eo[n]  = (n != g && s < NP) ? po[s*NPD+n] : 1'b0;
         eoe[n] = (n != g && s < NP) ? pe[s*NPD+n] : 1'b0;
      end
      if (commit) m_sel[m_pad] = m_new;
      @(posedge i_clk);
      #1;
      chk("pad_out", o_pad_out, eo);
      chk("pad_oe", o_pad_oe, eoe);
      chk("done", o_cfg_done, ed);
      chk("err", o_cfg_err, ee);
      chk("sel_flat", o_sel_flat, exp_sel_flat());
      @(negedge i_clk);
   endtask

   // Hold valid until the request is taken, bounded.
   task automatic req(input int pad, input int sel);
      bit acc;
      for (int k = 0; k < 20; k++) begin
         acc = (m_busy == 0);
         cycle(1'b1, pad, sel);
         if (acc) return;
      end
      chk("req_timeout", 1'b0, 1'b1);
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cycle(1'b0, 0, 0);
   endtask

   initial begin
      bit hold, v, acc;
      int pad, sel;
      i_rst = 1'b1;
      i_cfg_valid = 1'b0; i_cfg_pad = '0; i_cfg_sel = '0;
      i_peripheral_out = '1; i_peripheral_oe = '1;
      model_reset();
      #2;
      chk("rst_ready", o_cfg_ready, 1'b1);
      chk("rst_sel", o_sel_flat, {NPD{3'b111}});
      chk("rst_oe", o_pad_oe, '0);
      chk("rst_done", o_cfg_done, 1'b0);
      @(negedge i_clk); @(negedge i_clk);
      chk("rst_pulses", {o_cfg_done, o_cfg_err}, 2'b00);
      i_rst = 1'b0;

      // Routing, break-before-make on pad 5 with both sources driving, error, no-op, park.
      req(2, 1); idle(4);
      req(5, 0); idle(2);
      force_oe = 1'b1; req(5, 3); idle(G + 2); force_oe = 1'b0;
      req(9, 0); req(15, 2); idle(1);
      req(2, 1); idle(1);
      req(4, 5); idle(G + 2);
      req(4, 5); idle(1);
      // Back-to-back switches with valid held throughout.
      req(1, 2); req(1, 4); req(1, 0); idle(G + 2);

      // Asynchronous reset in the middle of a gap.
      req(6, 2); cycle(1'b0, 0, 0);
      #3 i_rst = 1'b1;
      #1;
      chk("mid_rst_ready", o_cfg_ready, 1'b1);
      chk("mid_rst_sel", o_sel_flat, {NPD{3'b111}});
      chk("mid_rst_oe", o_pad_oe, '0);
      chk("mid_rst_done", o_cfg_done, 1'b0);
      model_reset();
      @(posedge i_clk); #1;
      chk("mid_rst_done_edge", o_cfg_done, 1'b0);
      @(negedge i_clk);
      i_rst = 1'b0;

      hold = 0; v = 0; pad = 0; sel = 0;
      for (int i = 0; i < 600; i++) begin
         if (!hold) begin
            v   = ($urandom_range(0, 2) != 0);
            pad = $urandom_range(0, 9);
            if (pad < NPD && $urandom_range(0, 3) == 0) sel = m_sel[pad];
            else sel = $urandom_range(0, 7);
         end
         acc = (m_busy == 0);
         cycle(v, pad, sel);
         hold = v && !acc;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/pinmux_bbm_ctrl.md
# pinmux_bbm_ctrl

Registered, multi-pad pin multiplexer with a serialised configuration port and break-before-make switching. Each of `NUM_PADS` pads selects one of `NUM_PERIPHERALS` peripheral output/enable pairs by a per-pad select register. Before a select is changed, the pad's drive is forced off for a programmable gap. This prevents two peripherals from contending on a pad during reconfiguration. The block sits between the peripheral cluster and the pad ring, replacing the combinational per-pad muxes.

## Interface
Parameters:
- `NUM_PERIPHERALS`, default 4: number of selectable sources per pad.
- `NUM_PADS`, default 8: number of pads.
- `SEL_WIDTH`, default 3: select width. Must satisfy 2^SEL_WIDTH > NUM_PERIPHERALS.
- `PAD_IDX_WIDTH`, default 3: width of the config pad index.
- `GAP_CYCLES`, default 2: break-before-make gap. Must be ≥1.
- `RESET_SEL`, default all-ones: reset value of every select (parked).

Ports (clock and reset first):
- `i_clk`, input, 1 bit: clock.
- `i_rst`, input, 1 bit: reset, asynchronous, active-high.
- `i_peripheral_out`, input, NUM_PERIPHERALS*NUM_PADS bits: the bit for peripheral p, pad n is at index p*NUM_PADS+n.
- `i_peripheral_oe`, input, NUM_PERIPHERALS*NUM_PADS bits: same packing as `i_peripheral_out`.
- `i_cfg_valid`, input, 1 bit: config request.
- `i_cfg_pad`, input, PAD_IDX_WIDTH bits: target pad.
- `i_cfg_sel`, input, SEL_WIDTH bits: new select.
- `o_cfg_ready`, output, 1 bit: block can accept a request.
- `o_cfg_done`, output, 1 bit: single-cycle pulse when a select takes effect.
- `o_cfg_err`, output, 1 bit: single-cycle pulse for a rejected request.
- `o_sel_flat`, output, NUM_PADS*SEL_WIDTH bits: readback of all select registers. Pad n is at bits [(n+1)*SEL_WIDTH-1 : n*SEL_WIDTH].
- `o_pad_out`, output, NUM_PADS bits: registered pad data.
- `o_pad_oe`, output, NUM_PADS bits: registered pad enable.

## Operation
- **Select decode:** sel[n] < NUM_PERIPHERALS routes peripheral sel[n] to pad n. sel[n] ≥ NUM_PERIPHERALS is parked: out=0, oe=0.
- **Gate:** a pad is gated when it is the target pad and either:
  - the FSM is in GAP, or
  - the FSM is in IDLE and is accepting a switching request this cycle.
  A gated pad drives out=0, oe=0.
- **Pad output registers:** o_pad_out/o_pad_oe are updated every edge from the decoded, gated value.
- **FSM states:** IDLE and GAP.
- **o_cfg_ready:** equals (state==IDLE).
- **Acceptance:** a request is accepted when i_cfg_valid && o_cfg_ready.
- **IDLE, accepted request, one of three outcomes:**
  - i_cfg_pad ≥ NUM_PADS: pulse o_cfg_err next cycle and stay in IDLE. No register changes.
  - i_cfg_sel equals the current sel[pad]: no-op. Pulse o_cfg_done next cycle and stay in IDLE. The pad is not gated.
  - Otherwise: latch the pad and select, load cnt=GAP_CYCLES-1, and go to GAP.
- **GAP:**
  - If cnt>0, decrement cnt.
  - If cnt==0, write sel[pad]=latched select, pulse o_cfg_done, and go to IDLE.
- **Non-target pads** are never gated and keep following their peripherals throughout.
- **Requests in GAP:** ignored because ready is low. The requester must hold valid until it is accepted.
- **Reset:** from any state, return to IDLE and clear cnt.
  - Every sel resets to RESET_SEL.
  - o_pad_out, o_pad_oe, o_cfg_done and o_cfg_err reset to 0.
  - o_cfg_ready is 1 during and after reset.

## Timing
- **Data path latency:** a change on a peripheral input appears on the pad 1 cycle later (registered).
- **Switch sequence:** let a request be accepted at edge E.
  - The pad reads oe=0, out=0 from edge E.
  - GAP occupies the cycles ending at edges E+1 … E+GAP_CYCLES.
  - sel updates, o_cfg_done=1 and ready rises after edge E+GAP_CYCLES.
  - The new source drives the pad from edge E+GAP_CYCLES+1.
  - Total forced-off window is GAP_CYCLES+1 cycles. The old source is never visible after edge E.
- **Throughput:**
  - Back-to-back switching requests: one per GAP_CYCLES+1 cycles.
  - No-op and error requests: one per cycle.
- **Pulse timing:** o_cfg_done and o_cfg_err are registered and high for exactly 1 cycle.
- **o_sel_flat** reflects the register state directly. It changes at the same edge as the o_cfg_done assertion.
- **Switching to parked:** the gap still applies. Leaving the parked state also applies the gap.

## Test plan
- **Reset:** assert i_rst mid-GAP (GAP_CYCLES=4, cnt=2). Expect ready=1, all sel=3'b111, o_pad_oe=0, no o_cfg_done pulse, asynchronously.
- **Routing:** set sel[2]=1, then toggle peripheral-1 pad-2 out/oe. Expect o_pad_out[2]/o_pad_oe[2] to follow 1 cycle later; pad 2 ignores peripherals 0, 2 and 3.
- **Break-before-make:** with GAP_CYCLES=2, switch pad 5 from 0 to 3 while both sources have oe=1, out differing. Expect o_pad_oe[5]=0 for exactly 3 cycles, then peripheral 3's values; o_cfg_done 1 cycle at edge E+2; other pads undisturbed.
- **Error:** request pad=9 with NUM_PADS=8, PAD_IDX_WIDTH=4. Expect o_cfg_err pulse, no sel change, ready stays 1.
- **No-op and park:**
  - Request sel equal to the current value: expect o_cfg_done next cycle with no gating.
  - Request sel=5 with NUM_PERIPHERALS=4: expect the pad parked (0/0) after the gap.
- **Back-to-back:** hold i_cfg_valid continuously with 3 different switching requests. Expect acceptances spaced GAP_CYCLES+1 apart, ready low during GAP, all 3 applied in order.
